rom_token_sequencer: RTL and testbench

Walks the calculator's token ROM from index 0 and turns raw key codes into an item stream for the evaluator. It accumulates digit runs into 16-bit operands and emits them alternating with operators, then emits an end marker at `#`. It sits between the combinational-read token ROM and the expression evaluator. It owns the ROM index, checks expression syntax, and reports errors.

---
 rtl/calc_tok_pkg.sv | 40 ++++
 rtl/rom_token_sequencer_if.sv | 31 +++
 rtl/calc_tok_classify.sv | 23 ++
 rtl/rom_token_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_rom_token_sequencer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_tok_pkg.sv
// Shared token-code, item-kind, error-code and state definitions for the
// calculator token sequencer and the evaluator's input checker.
package calc_tok_pkg;

    localparam int unsigned IDX_W = 7;

    localparam logic [7:0] DIGIT_MAX = 8'd9;
    localparam logic [7:0] TOK_END   = 8'd10;
    localparam logic [7:0] TOK_ADD   = 8'd20;
    localparam logic [7:0] TOK_SUB   = 8'd21;
    localparam logic [7:0] TOK_MUL   = 8'd22;
    localparam logic [7:0] TOK_DIV   = 8'd23;

    localparam logic [1:0] KIND_NUM = 2'd0;
    localparam logic [1:0] KIND_OP  = 2'd1;
    localparam logic [1:0] KIND_END = 2'd2;

    localparam logic [1:0] ERR_BAD_CODE = 2'd0;
    localparam logic [1:0] ERR_SYNTAX   = 2'd1;
    localparam logic [1:0] ERR_NO_TERM  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StEmitNum,
        StEmitOp,
        StEmitEnd,
        StDone,
        StErr
    } state_e;

    // Operator tokens are contiguous, so the op code is the offset from TOK_ADD.
    function automatic logic [1:0] tok_to_op(input logic [7:0] code);
        logic [7:0] ofs;
        ofs = code - TOK_ADD;
        return ofs[1:0];
    endfunction

endpackage

// File: rtl/rom_token_sequencer_if.sv
// Token ROM read port and evaluator item handshake, bundled for the sequencer.
interface rom_token_sequencer_if #(
    parameter int unsigned VW = 16
) ();

    logic [6:0]    rom_index;
    logic [7:0]    rom_data;
    logic          item_valid;
    logic          item_ready;
    logic [1:0]    item_kind;
    logic [VW-1:0] item_value;

    modport master (
        output rom_index,
        input  rom_data,
        output item_valid,
        input  item_ready,
        output item_kind,
        output item_value
    );

    modport slave (
        input  rom_index,
        output rom_data,
        input  item_valid,
        output item_ready,
        input  item_kind,
        input  item_value
    );

endinterface

// File: rtl/calc_tok_classify.sv
// Combinational decode of a raw key code; exactly one of the is_* flags is set.
module calc_tok_classify
    import calc_tok_pkg::*;
(
    input  logic [7:0] code_i,
    output logic       is_digit_o,
    output logic [3:0] digit_o,
    output logic       is_op_o,
    output logic [1:0] op_o,
    output logic       is_end_o,
    output logic       is_bad_o
);

    always_comb begin
        is_digit_o = (code_i <= DIGIT_MAX);
        digit_o    = code_i[3:0];
        is_op_o    = (code_i >= TOK_ADD) && (code_i <= TOK_DIV);
        op_o       = tok_to_op(code_i);
        is_end_o   = (code_i == TOK_END);
        is_bad_o   = !(is_digit_o || is_op_o || is_end_o);
    end

endmodule

// File: rtl/rom_token_sequencer.sv
// Walks the token ROM, folds digit runs into operands and emits NUM/OP/END
// items to the evaluator, stopping in ERR on any malformed expression.
module rom_token_sequencer
    import calc_tok_pkg::*;
#(
    parameter int unsigned DEPTH = 100,
    parameter int unsigned VW    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    rom_token_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH);

    logic       is_digit, is_op, is_end, is_bad;
    logic [3:0] digit;
    logic [1:0] op_code;

    calc_tok_classify u_classify (
        .code_i     (bus.rom_data),
        .is_digit_o (is_digit),
        .digit_o    (digit),
        .is_op_o    (is_op),
        .op_o       (op_code),
        .is_end_o   (is_end),
        .is_bad_o   (is_bad)
    );

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VW-1:0]    acc_q, acc_d;
    logic             have_num_q, have_num_d;
    logic             pend_end_q, pend_end_d;
    logic [1:0]       pend_op_q, pend_op_d;
    logic             valid_q, valid_d;
    logic [1:0]       kind_q, kind_d;
    logic [VW-1:0]    value_q, value_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [VW+3:0]    acc_ext;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        have_num_d = have_num_q;
        pend_end_d = pend_end_q;
        pend_op_d  = pend_op_q;
        err_code_d = err_code_q;
        // acc*10 + d with four guard bits so any overflow is visible above VW.
        acc_ext    = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {{VW{1'b0}}, digit};

        case (state_q)
            StIdle, StErr: begin
                if (start) begin
                    state_d    = StFetch;
                    idx_d      = '0;
                    acc_d      = '0;
                    have_num_d = 1'b0;
                    pend_end_d = 1'b0;
                    pend_op_d  = '0;
                    err_code_d = ERR_BAD_CODE;
                end
            end
            StFetch: begin
                if (idx_q == LAST_IDX) begin
                    state_d    = StErr;
                    err_code_d = ERR_NO_TERM;
                end else begin
                    unique case (1'b1)
                        is_bad: begin
                            state_d    = StErr;
                            err_code_d = ERR_BAD_CODE;
                        end
                        is_digit: begin
                            if (|acc_ext[VW+3:VW]) begin
                                state_d    = StErr;
                                err_code_d = ERR_OVERFLOW;
                            end else begin
                                acc_d      = acc_ext[VW-1:0];
                                have_num_d = 1'b1;
                                idx_d      = idx_q + IDX_W'(1);
                            end
                        end
                        is_op: begin
                            if (!have_num_q) begin
                                state_d    = StErr;
                                err_code_d = ERR_SYNTAX;
                            end else begin
                                pend_op_d  = op_code;
                                pend_end_d = 1'b0;
                                idx_d      = idx_q + IDX_W'(1);
                                state_d    = StEmitNum;
                            end
                        end
                        is_end: begin
                            if (!have_num_q) begin
                                state_d    = StErr;
                                err_code_d = ERR_SYNTAX;
                            end else begin
                                pend_end_d = 1'b1;
                                state_d    = StEmitNum;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StEmitNum: begin
                if (bus.item_ready) begin
                    acc_d      = '0;
                    have_num_d = 1'b0;
                    state_d    = pend_end_q ? StEmitEnd : StEmitOp;
                end
            end
            StEmitOp:  if (bus.item_ready) state_d = StFetch;
            StEmitEnd: if (bus.item_ready) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        // Item outputs are a registered function of the next state only.
        valid_d = state_d inside {StEmitNum, StEmitOp, StEmitEnd};
        kind_d  = KIND_NUM;
        value_d = '0;
        case (state_d)
            StEmitNum: value_d = acc_d;
            StEmitOp: begin
                kind_d  = KIND_OP;
                value_d = VW'(pend_op_d);
            end
            StEmitEnd: kind_d = KIND_END;
            default: ;
        endcase
        busy_d = !(state_d inside {StIdle, StErr});
        done_d = (state_d == StDone);
        err_d  = (state_d == StErr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            acc_q      <= '0;
            have_num_q <= 1'b0;
            pend_end_q <= 1'b0;
            pend_op_q  <= '0;
            valid_q    <= 1'b0;
            kind_q     <= '0;
            value_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            have_num_q <= have_num_d;
            pend_end_q <= pend_end_d;
            pend_op_q  <= pend_op_d;
            valid_q    <= valid_d;
            kind_q     <= kind_d;
            value_q    <= value_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.rom_index  = idx_q;
    assign bus.item_valid = valid_q;
    assign bus.item_kind  = kind_q;
    assign bus.item_value = value_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign err_code       = err_code_q;

endmodule

// File: tb/tb_rom_token_sequencer.sv
// Directed and randomized checks of rom_token_sequencer against a token-list
// parser model of the expected item stream and error outcome.
module tb_rom_token_sequencer;

    localparam int DEPTH = 100;
    localparam int VW    = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, err;
    logic [1:0] err_code;

    rom_token_sequencer_if #(.VW(VW)) bus ();

    rom_token_sequencer #(
        .DEPTH (DEPTH),
        .VW    (VW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:127];
    assign bus.rom_data = rom[bus.rom_index];

    int checks = 0;
    int errors = 0;

    logic [1:0]  got_kind[$];
    logic [15:0] got_val[$];
    int          got_cyc[$];
    logic [1:0]  exp_kind[$];
    logic [15:0] exp_val[$];

    int         done_cyc;
    bit         err_seen;
    logic [1:0] err_code_seen;
    logic [6:0] err_idx_seen;
    logic [6:0] final_idx;
    int         stab_err;
    bit         err_c1, busy_c1;

    bit         exp_err;
    logic [1:0] exp_code;
    int         exp_idx;

    task automatic load_rom(input logic [63:0] toks, input int n);
        for (int i = 0; i < 128; i++) rom[i] = 8'hFF;
        for (int i = 0; i < n; i++) rom[i] = toks[(63 - 8 * i) -: 8];
    endtask

    // Reference: parse the ROM contents directly into the expected item list.
    task automatic run_model();
        int idx, acc, c;
        bit have, fin;
        exp_kind.delete();
        exp_val.delete();
        exp_err = 0; exp_code = 0;
        idx = 0; acc = 0; have = 0; fin = 0;
        while (!fin) begin
            if (idx == DEPTH) begin
                exp_err = 1; exp_code = 2'd2; fin = 1;
            end else begin
                c = int'(rom[idx]);
                if (c <= 9) begin
                    if (acc * 10 + c > 65535) begin
                        exp_err = 1; exp_code = 2'd3; fin = 1;
                    end else begin
                        acc = acc * 10 + c; have = 1; idx++;
                    end
                end else if (c >= 20 && c <= 23) begin
                    if (!have) begin
                        exp_err = 1; exp_code = 2'd1; fin = 1;
                    end else begin
                        exp_kind.push_back(2'd0); exp_val.push_back(16'(acc));
                        exp_kind.push_back(2'd1); exp_val.push_back(16'(c - 20));
                        acc = 0; have = 0; idx++;
                    end
                end else if (c == 10) begin
                    if (!have) begin
                        exp_err = 1; exp_code = 2'd1;
                    end else begin
                        exp_kind.push_back(2'd0); exp_val.push_back(16'(acc));
                        exp_kind.push_back(2'd2); exp_val.push_back(16'd0);
                    end
                    fin = 1;
                end else begin
                    exp_err = 1; exp_code = 2'd0; fin = 1;
                end
            end
        end
        exp_idx = idx;
    endtask

    function automatic int item_diff();
        int n;
        n = (got_kind.size() > exp_kind.size()) ? got_kind.size() : exp_kind.size();
        for (int i = 0; i < n; i++) begin
            if (i >= got_kind.size() || i >= exp_kind.size()) return i;
            if (got_kind[i] !== exp_kind[i] || got_val[i] !== exp_val[i]) return i;
        end
        return -1;
    endfunction

    // mode 0: ready high; 1: ready 1-of-3; 2: random ready; 3: ready high + stray starts
    task automatic run_scan(input int mode, input int max_cyc);
        int cyc;
        bit fin, prev_stall;
        logic [1:0] prev_kind;
        logic [15:0] prev_val;
        got_kind.delete(); got_val.delete(); got_cyc.delete();
        done_cyc = -1; err_seen = 0; err_code_seen = 0; err_idx_seen = 0; stab_err = 0;
        prev_stall = 0; prev_kind = 0; prev_val = 0;
        @(negedge clk);
        start = 1'b1;
        cyc = 0; fin = 0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start = (mode == 3 && (cyc == 3 || cyc == 8)) ? 1'b1 : 1'b0;
            if (cyc == 1) begin err_c1 = err; busy_c1 = busy; end
            if (prev_stall && (!bus.item_valid || bus.item_kind !== prev_kind ||
                               bus.item_value !== prev_val)) stab_err++;
            case (mode)
                1: bus.item_ready = (cyc % 3 == 0);
                2: bus.item_ready = 1'($urandom_range(0, 1));
                default: bus.item_ready = 1'b1;
            endcase
            if (bus.item_valid && bus.item_ready) begin
                got_kind.push_back(bus.item_kind);
                got_val.push_back(bus.item_value);
                got_cyc.push_back(cyc);
            end
            prev_stall = bus.item_valid && !bus.item_ready;
            prev_kind = bus.item_kind;
            prev_val = bus.item_value;
            if (done) begin done_cyc = cyc; fin = 1; end
            if (err) begin
                err_seen = 1; err_code_seen = err_code; err_idx_seen = bus.rom_index; fin = 1;
            end
            if (cyc >= max_cyc) fin = 1;
        end
        final_idx = bus.rom_index;
        bus.item_ready = 1'b1;
    endtask

    task automatic load_basic();
        load_rom({8'd1, 8'd5, 8'd22, 8'd1, 8'd0, 8'd20, 8'd9, 8'd10}, 8);
    endtask

    task automatic test_reset();
        logic [32:0] outs;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        outs = {bus.item_valid, bus.item_kind, bus.item_value, busy, done, err, err_code,
                bus.rom_index};
        checks++;
        if (outs !== 33'd0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0", outs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int exp_cyc[6];
        int d;
        exp_cyc = '{4, 5, 9, 10, 13, 14};
        load_basic(); run_model(); run_scan(0, 60);
        d = item_diff();
        checks++;
        if (d != -1) begin
            errors++; $display("FAIL basic_items: diff at %0d got %0d items required %0d",
                               d, got_kind.size(), exp_kind.size());
        end
        checks++;
        if (got_kind.size() != 6 || got_val[0] !== 16'd15 || got_val[2] !== 16'd10) begin
            errors++; $display("FAIL basic_values: got %0d items first %0d required 6 items 15",
                               got_kind.size(), got_val.size() > 0 ? got_val[0] : 16'd0);
        end
        for (int i = 0; i < 6 && i < got_cyc.size(); i++) begin
            checks++;
            if (got_cyc[i] != exp_cyc[i]) begin
                errors++; $display("FAIL basic_item_cycle[%0d]: got c%0d required c%0d",
                                   i, got_cyc[i], exp_cyc[i]);
            end
        end
        checks++;
        if (done_cyc != 15) begin
            errors++; $display("FAIL basic_done_cycle: got %0d required 15", done_cyc);
        end
        checks++;
        if (final_idx !== 7'd7) begin
            errors++; $display("FAIL basic_rom_index: got %0d required 7", final_idx);
        end
    endtask

    task automatic test_stall();
        int d;
        load_basic(); run_model(); run_scan(1, 120);
        d = item_diff();
        checks++;
        if (d != -1 || done_cyc < 0) begin
            errors++; $display("FAIL stall_items: diff at %0d got %0d items required %0d done %0d",
                               d, got_kind.size(), exp_kind.size(), done_cyc);
        end
        checks++;
        if (stab_err != 0) begin
            errors++; $display("FAIL stall_stability: got %0d violations required 0", stab_err);
        end
    endtask

    task automatic test_overflow();
        int d;
        load_rom({8'd6, 8'd5, 8'd5, 8'd3, 8'd5, 8'd10, 16'd0}, 6);
        run_model(); run_scan(0, 60);
        d = item_diff();
        checks++;
        if (d != -1 || done_cyc < 0 || got_val.size() < 1 || got_val[0] !== 16'd65535) begin
            errors++; $display("FAIL max_operand: got %0d items done %0d required NUM 65535 END",
                               got_kind.size(), done_cyc);
        end
        load_rom({8'd6, 8'd5, 8'd5, 8'd3, 8'd6, 24'd0}, 5);
        run_scan(0, 60);
        checks++;
        if (!err_seen || err_code_seen !== 2'd3 || err_idx_seen !== 7'd4 || got_kind.size() != 0)
        begin
            errors++; $display("FAIL overflow: got err %0d code %0d idx %0d items %0d required 1 3 4 0",
                               err_seen, err_code_seen, err_idx_seen, got_kind.size());
        end
    endtask

    task automatic test_syntax_and_bad();
        int d;
        load_rom({8'd22, 8'd1, 8'd10, 40'd0}, 3);
        run_scan(0, 60);
        checks++;
        if (!err_seen || err_code_seen !== 2'd1 || got_kind.size() != 0) begin
            errors++; $display("FAIL leading_op: got err %0d code %0d items %0d required 1 1 0",
                               err_seen, err_code_seen, got_kind.size());
        end
        load_rom({8'd1, 8'd20, 8'd10, 40'd0}, 3);
        run_model(); run_scan(0, 60);
        d = item_diff();
        checks++;
        if (d != -1 || exp_kind.size() != 2 || !err_seen || err_code_seen !== 2'd1) begin
            errors++; $display("FAIL trailing_op: diff %0d items %0d err %0d code %0d required -1 2 1 1",
                               d, got_kind.size(), err_seen, err_code_seen);
        end
        load_rom({8'd3, 8'd15, 48'd0}, 2);
        run_scan(0, 60);
        checks++;
        if (!err_seen || err_code_seen !== 2'd0 || err_idx_seen !== 7'd1) begin
            errors++; $display("FAIL bad_code: got err %0d code %0d idx %0d required 1 0 1",
                               err_seen, err_code_seen, err_idx_seen);
        end
    endtask

    task automatic test_no_term_restart();
        int d;
        for (int i = 0; i < 128; i++) rom[i] = 8'd0;
        run_scan(0, 200);
        checks++;
        if (!err_seen || err_code_seen !== 2'd2 || err_idx_seen !== 7'd100) begin
            errors++; $display("FAIL no_term: got err %0d code %0d idx %0d required 1 2 100",
                               err_seen, err_code_seen, err_idx_seen);
        end
        load_basic(); run_model(); run_scan(0, 60);
        checks++;
        if (err_c1 !== 1'b0 || busy_c1 !== 1'b1) begin
            errors++; $display("FAIL restart_from_err: got err %0d busy %0d required 0 1",
                               err_c1, busy_c1);
        end
        d = item_diff();
        checks++;
        if (d != -1 || done_cyc != 15) begin
            errors++; $display("FAIL restart_items: diff %0d done %0d required -1 15", d, done_cyc);
        end
    endtask

    task automatic test_start_ignored();
        int d;
        load_basic(); run_model(); run_scan(3, 60);
        d = item_diff();
        checks++;
        if (d != -1 || done_cyc != 15) begin
            errors++; $display("FAIL start_ignored: diff %0d done %0d required -1 15", d, done_cyc);
        end
    endtask

    task automatic test_reset_mid_stall();
        bit found;
        int leaks;
        logic [32:0] outs;
        load_basic();
        bus.item_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.item_valid && bus.item_kind == 2'd1) found = 1;
            else begin
                bus.item_ready = bus.item_valid && bus.item_kind == 2'd0;
                @(negedge clk);
            end
        end
        bus.item_ready = 1'b0;
        checks++;
        if (!found) begin
            errors++; $display("FAIL reach_op_stall: got no OP item within 40 cycles required OP");
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.item_valid !== 1'b1 || bus.item_kind !== 2'd1 || bus.item_value !== 16'd2) begin
            errors++; $display("FAIL op_stall_hold: got v%0d k%0d val %0d required 1 1 2",
                               bus.item_valid, bus.item_kind, bus.item_value);
        end
        rst_n = 1'b0;
        @(negedge clk);
        outs = {bus.item_valid, bus.item_kind, bus.item_value, busy, done, err, err_code,
                bus.rom_index};
        checks++;
        if (outs !== 33'd0) begin
            errors++; $display("FAIL reset_mid_scan: got %h required 0", outs);
        end
        rst_n = 1'b1;
        bus.item_ready = 1'b1;
        leaks = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.item_valid || done) leaks++;
        end
        checks++;
        if (leaks != 0) begin
            errors++; $display("FAIL post_reset_quiet: got %0d active cycles required 0", leaks);
        end
    endtask

    task automatic test_random();
        int pos, nops, nd, mode, d;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 128; i++) rom[i] = 8'hFF;
            pos = 0;
            nops = $urandom_range(1, 4);
            for (int k = 0; k < nops; k++) begin
                nd = $urandom_range(1, 5);
                for (int j = 0; j < nd; j++) begin
                    rom[pos] = 8'($urandom_range(0, 9));
                    pos++;
                end
                rom[pos] = (k == nops - 1) ? 8'd10 : 8'(20 + $urandom_range(0, 3));
                pos++;
            end
            if ($urandom_range(0, 3) == 0) rom[$urandom_range(0, pos - 1)] = 8'($urandom_range(0, 30));
            mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            run_model();
            run_scan(mode, 400);
            d = item_diff();
            checks++;
            if (d != -1) begin
                errors++; $display("FAIL random_items[%0d]: diff at %0d got %0d items required %0d",
                                   it, d, got_kind.size(), exp_kind.size());
            end
            checks++;
            if (err_seen !== exp_err ||
                (exp_err && (err_code_seen !== exp_code || int'(err_idx_seen) != exp_idx)) ||
                (!exp_err && done_cyc < 0)) begin
                errors++; $display("FAIL random_status[%0d]: got err %0d code %0d idx %0d done %0d required err %0d code %0d idx %0d",
                                   it, err_seen, err_code_seen, err_idx_seen, done_cyc,
                                   exp_err, exp_code, exp_idx);
            end
            checks++;
            if (stab_err != 0) begin
                errors++; $display("FAIL random_stability[%0d]: got %0d violations required 0",
                                   it, stab_err);
            end
        end
    endtask

    initial begin
        bus.item_ready = 1'b1;
        for (int i = 0; i < 128; i++) rom[i] = 8'hFF;
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_syntax_and_bad();
        test_no_term_restart();
        test_start_ignored();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
